// File: rtl/viterbi_pkg.sv
// Shared trellis constants, FSM encoding and symbol function used by the
// convolutional encoder and by the Viterbi decoder branch-metric logic.
package viterbi_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } enc_state_t;

    // Symbol is {c0,c1}; the generator MSB taps the current input bit.
    function automatic logic [1:0] conv_sym(input logic u, input logic [K-2:0] s);
        logic [K-1:0] w;
        w = {u, s};
        return {^(w & G0), ^(w & G1)};
    endfunction

endpackage

// File: rtl/conv_encoder_tx_if.sv
// Info-bit input handshake and coded-symbol output handshake of the encoder.
interface conv_encoder_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sym;
    logic       out_tail;
    logic       out_last;

    // master: bit source / symbol sink; slave: the encoder itself.
    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_tail, out_last
    );
    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_tail, out_last
    );
endinterface

// File: rtl/conv_trellis_step.sv
// Combinational single trellis transition: (u, s) -> coded symbol and next state.
module conv_trellis_step
    import viterbi_pkg::*;
(
    input  logic         i_u,
    input  logic [K-2:0] i_s,
    output logic [1:0]   o_sym,
    output logic [K-2:0] o_s_next
);

    assign o_sym    = conv_sym(i_u, i_s);
    assign o_s_next = {i_u, i_s[K-2:1]};

endmodule

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 K=3 convolutional encoder with a single-stage output register
// and K-1 zero tail symbols appended to every frame.
module conv_encoder_tx
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_encoder_tx_if.slave bus
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(K);

    enc_state_t    r_state;
    enc_state_t    w_state_next;
    logic [K-2:0]  r_s;
    logic [K-2:0]  w_s_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic [TW-1:0] r_tail_cnt;
    logic [TW-1:0] w_tail_cnt_next;

    logic          r_out_valid;
    logic [1:0]    r_out_sym;
    logic          r_out_tail;
    logic          r_out_last;

    logic          w_slot_free;
    logic          w_load;
    logic          w_tail_sym;
    logic          w_last_sym;
    logic          w_in_ready;
    logic          w_u;
    logic [1:0]    w_step_sym;
    logic [K-2:0]  w_step_s_next;

    assign w_slot_free = !r_out_valid || bus.out_ready;
    // Tail symbols are encoded with a forced zero input to flush the state.
    assign w_u = (r_state == DATA) ? bus.in_bit : 1'b0;

    conv_trellis_step u_step (
        .i_u      (w_u),
        .i_s      (r_s),
        .o_sym    (w_step_sym),
        .o_s_next (w_step_s_next)
    );

    always_comb begin
        w_state_next    = r_state;
        w_s_next        = r_s;
        w_count_next    = r_count;
        w_tail_cnt_next = r_tail_cnt;
        w_load          = 1'b0;
        w_tail_sym      = 1'b0;
        w_last_sym      = 1'b0;
        w_in_ready      = 1'b0;
        case (r_state)
            DATA: begin
                w_in_ready = w_slot_free;
                if (bus.in_valid && w_slot_free) begin
                    w_load       = 1'b1;
                    w_s_next     = w_step_s_next;
                    w_count_next = r_count + CW'(1);
                    if (bus.in_last || (r_count + CW'(1)) == CW'(FRAME_LEN)) begin
                        w_state_next    = TAIL;
                        w_tail_cnt_next = '0;
                    end
                end
            end
            TAIL: begin
                if (w_slot_free) begin
                    w_load          = 1'b1;
                    w_tail_sym      = 1'b1;
                    w_s_next        = w_step_s_next;
                    w_tail_cnt_next = r_tail_cnt + TW'(1);
                    if (r_tail_cnt == TW'(K - 2)) begin
                        w_last_sym   = 1'b1;
                        w_state_next = DATA;
                        w_count_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= DATA;
            r_s         <= '0;
            r_count     <= '0;
            r_tail_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_sym   <= 2'b00;
            r_out_tail  <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_s        <= w_s_next;
            r_count    <= w_count_next;
            r_tail_cnt <= w_tail_cnt_next;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_sym   <= w_step_sym;
                r_out_tail  <= w_tail_sym;
                r_out_last  <= w_last_sym;
            end else if (bus.out_ready) begin
                // Clear the payload on pop so an idle output never shows stale data.
                r_out_valid <= 1'b0;
                r_out_sym   <= 2'b00;
                r_out_tail  <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = rst_n && w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sym   = r_out_sym;
    assign bus.out_tail  = r_out_tail;
    assign bus.out_last  = r_out_last;

endmodule
